// File: rtl/rl_ram_1r1w_rdport_if.sv
// Bundle of request, response and RAM read-port signals for rl_ram_1r1w_rdport.
// Signal suffixes are from the burst engine's point of view.
interface rl_ram_1r1w_rdport_if #(
  parameter int unsigned ABITS = 10,
  parameter int unsigned DBITS = 32,
  parameter int unsigned LBITS = 8
);
  logic [ABITS-1:0] req_addr_i;
  logic [LBITS-1:0] req_len_i;
  logic             req_valid_i;
  logic             req_ready_o;
  logic [DBITS-1:0] rsp_data_o;
  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic [ABITS-1:0] ram_raddr_o;
  logic             ram_re_o;
  logic [DBITS-1:0] ram_dout_i;

  // Burst engine side
  modport slave (
    input  req_addr_i, req_len_i, req_valid_i, rsp_ready_i, ram_dout_i,
    output req_ready_o, rsp_data_o, rsp_valid_o, ram_raddr_o, ram_re_o
  );

  // Requester / consumer / RAM side
  modport master (
    output req_addr_i, req_len_i, req_valid_i, rsp_ready_i, ram_dout_i,
    input  req_ready_o, rsp_data_o, rsp_valid_o, ram_raddr_o, ram_re_o
  );
endinterface

// File: rtl/rl_ram_1r1w_rdport.sv
// Burst read engine for the read port of a 1R1W RAM with 1-cycle read latency.
// Issues auto-incrementing reads and returns data through a 2-entry response
// buffer; a credit check on issue guarantees the buffer never overflows.
// Interface parameters must match the values used here.
module rl_ram_1r1w_rdport #(
  parameter int unsigned ABITS = 10,
  parameter int unsigned DBITS = 32,
  parameter int unsigned LBITS = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  rl_ram_1r1w_rdport_if.slave     bus
);

  localparam logic StIdle  = 1'b0;
  localparam logic StBurst = 1'b1;

  logic             state_q, state_d;
  logic [ABITS-1:0] addr_q, addr_d;
  logic [LBITS-1:0] rem_q, rem_d;
  logic             inflight_q;
  logic [1:0]       count_q, count_d;
  logic             rd_ptr_q, wr_ptr_q;
  logic [DBITS-1:0] buf_q [2];

  logic push, pop, issue;

  // Words already buffered plus the one on its way count against the 2 slots;
  // a pop this cycle frees a slot in time for a same-cycle issue.
  always_comb begin
    push  = inflight_q;
    pop   = (count_q != 2'd0) && bus.rsp_ready_i;
    issue = (state_q == StBurst) &&
            ((({1'b0, count_q} + {2'b00, inflight_q}) < 3'd2) || pop);
  end

  // Drive outputs from state and the issue decision
  always_comb begin
    bus.req_ready_o = (state_q == StIdle);
    bus.ram_raddr_o = addr_q;
    bus.ram_re_o    = issue;
    bus.rsp_valid_o = (count_q != 2'd0);
    bus.rsp_data_o  = buf_q[rd_ptr_q];
  end

  // FSM, address and remaining-count next state
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    case (state_q)
      StIdle: begin
        if (bus.req_valid_i) begin
          addr_d  = bus.req_addr_i;
          rem_d   = bus.req_len_i;
          state_d = StBurst;
        end
      end
      StBurst: begin
        if (issue) begin
          addr_d = addr_q + ABITS'(1);
          if (rem_q == '0) begin
            state_d = StIdle;
          end else begin
            rem_d = rem_q - LBITS'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  // Control state; reset discards any words of an interrupted burst
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      rem_q      <= '0;
      inflight_q <= 1'b0;
      count_q    <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      inflight_q <= issue;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_q ^ pop;
      wr_ptr_q   <= wr_ptr_q ^ push;
    end
  end

  // Buffer storage; contents beyond occupancy are don't-care so no reset
  always_ff @(posedge clk_i) begin
    if (push) begin
      buf_q[wr_ptr_q] <= bus.ram_dout_i;
    end
  end

endmodule

// File: tb/tb_rl_ram_1r1w_rdport.sv
// Self-checking bench for rl_ram_1r1w_rdport: behavioural RAM, request queue
// and an expected-word queue built from address arithmetic on each accepted
// request.
module tb_rl_ram_1r1w_rdport;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rl_ram_1r1w_rdport_if #(.ABITS(10), .DBITS(32), .LBITS(8)) bus ();

  rl_ram_1r1w_rdport #(.ABITS(10), .DBITS(32), .LBITS(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  logic [31:0] mem [1024];

  // RAM with 1-cycle read latency
  always @(posedge clk) begin
    if (bus.ram_re_o) bus.ram_dout_i <= mem[bus.ram_raddr_o];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  int          rq_addr [$];
  int          rq_len  [$];
  logic [31:0] exp_q   [$];
  int          exp_addr_q [$];
  logic [31:0] got_q   [$];
  int          raddr_q [$];
  int          re_cyc_q [$];
  int          pop_cyc_q [$];
  int          stab_err, credit_err, issued, popped;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got none, required completion");
    $fatal(1);
  end

  task automatic clear_obs();
    rq_addr.delete(); rq_len.delete();
    exp_q.delete(); exp_addr_q.delete(); got_q.delete();
    raddr_q.delete(); re_cyc_q.delete(); pop_cyc_q.delete();
    stab_err = 0; credit_err = 0; issued = 0; popped = 0;
  endtask

  function automatic bit data_matches();
    if (got_q.size() != exp_q.size()) return 1'b0;
    foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit addr_matches();
    if (raddr_q.size() != exp_addr_q.size()) return 1'b0;
    foreach (exp_addr_q[i]) if (raddr_q[i] != exp_addr_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Drives queued requests and rsp_ready (mode 0: high, 1: random,
  // 2: low for 10 cycles after first rsp_valid), records what the DUT does.
  task automatic collect(input int mode, input int budget, output bit timeout);
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    bit          seen = 1'b0;
    int          low_cnt = 0;
    int          idle_cnt = 0;
    int          n = 0;
    bit          rdy;
    timeout = 1'b0;
    while (idle_cnt < 4) begin
      @(negedge clk);
      if (rq_addr.size() > 0) begin
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = 10'(rq_addr[0]);
        bus.req_len_i   = 8'(rq_len[0]);
        if (bus.req_ready_o) begin
          for (int i = 0; i <= rq_len[0]; i++) begin
            exp_addr_q.push_back((rq_addr[0] + i) % 1024);
            exp_q.push_back(mem[(rq_addr[0] + i) % 1024]);
          end
          void'(rq_addr.pop_front());
          void'(rq_len.pop_front());
        end
      end else begin
        bus.req_valid_i = 1'b0;
      end
      case (mode)
        1: rdy = 1'($urandom % 2);
        2: begin
          if (bus.rsp_valid_o) seen = 1'b1;
          if (seen && low_cnt < 10) begin
            rdy = 1'b0;
            low_cnt++;
          end else begin
            rdy = 1'b1;
          end
        end
        default: rdy = 1'b1;
      endcase
      bus.rsp_ready_i = rdy;
      #1;
      if (prev_stall && (!bus.rsp_valid_o || bus.rsp_data_o !== prev_data)) stab_err++;
      prev_stall = bus.rsp_valid_o && !rdy;
      prev_data  = bus.rsp_data_o;
      if (bus.ram_re_o) begin
        raddr_q.push_back(int'(bus.ram_raddr_o));
        re_cyc_q.push_back(cyc);
        issued++;
      end
      if (bus.rsp_valid_o && rdy) begin
        got_q.push_back(bus.rsp_data_o);
        pop_cyc_q.push_back(cyc);
        popped++;
      end
      if (issued - popped > 2) credit_err++;
      if (rq_addr.size() == 0 && got_q.size() >= exp_q.size()) idle_cnt++;
      else idle_cnt = 0;
      n++;
      if (n > budget) begin
        timeout = 1'b1;
        break;
      end
    end
    bus.req_valid_i = 1'b0;
    bus.rsp_ready_i = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = '0;
    bus.req_len_i   = '0;
    bus.rsp_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (bus.req_ready_o !== 1'b1) begin
      errors++; $display("FAIL reset_req_ready: got %b, required 1", bus.req_ready_o);
    end
    checks++;
    if (bus.rsp_valid_o !== 1'b0) begin
      errors++; $display("FAIL reset_rsp_valid: got %b, required 0", bus.rsp_valid_o);
    end
    checks++;
    if (bus.ram_re_o !== 1'b0 || bus.ram_raddr_o !== 10'd0) begin
      errors++;
      $display("FAIL reset_ram_port: got re=%b raddr=%0d, required re=0 raddr=0",
               bus.ram_re_o, bus.ram_raddr_o);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    mem[5] = 32'hA5A5_0001;
    @(negedge clk);
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = 10'd5;
    bus.req_len_i   = 8'd0;
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    #1;
    checks++;
    if (bus.ram_re_o !== 1'b1 || bus.ram_raddr_o !== 10'd5 || bus.req_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL single_issue: got re=%b raddr=%0d req_ready=%b, required 1/5/0",
               bus.ram_re_o, bus.ram_raddr_o, bus.req_ready_o);
    end
    @(negedge clk); #1;
    checks++;
    if (bus.ram_re_o !== 1'b0 || bus.req_ready_o !== 1'b1 || bus.rsp_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL single_after_issue: got re=%b req_ready=%b rsp_valid=%b, required 0/1/0",
               bus.ram_re_o, bus.req_ready_o, bus.rsp_valid_o);
    end
    @(negedge clk); #1;
    checks++;
    if (bus.rsp_valid_o !== 1'b1 || bus.rsp_data_o !== 32'hA5A5_0001) begin
      errors++;
      $display("FAIL single_rsp: got valid=%b data=%h, required 1/a5a50001",
               bus.rsp_valid_o, bus.rsp_data_o);
    end
    @(negedge clk); #1;
    checks++;
    if (bus.rsp_valid_o !== 1'b0) begin
      errors++; $display("FAIL single_rsp_once: got valid=%b, required 0", bus.rsp_valid_o);
    end
  endtask

  task automatic test_stream();
    bit to;
    for (int i = 0; i < 1024; i++) mem[i] = 32'(i);
    clear_obs();
    rq_addr.push_back(16); rq_len.push_back(7);
    collect(0, 100, to);
    checks++;
    if (to || !data_matches()) begin
      errors++;
      $display("FAIL stream_data: got %0d words (timeout=%0d), required 8 words 16..23",
               got_q.size(), to);
    end
    checks++;
    if (!addr_matches()) begin
      errors++; $display("FAIL stream_raddr: got %0d issues, required raddr 16..23", raddr_q.size());
    end
    checks++;
    if (re_cyc_q.size() != 8 || re_cyc_q[7] - re_cyc_q[0] != 7) begin
      errors++; $display("FAIL stream_issue_gapless: got %0d issues, required 8 consecutive",
                         re_cyc_q.size());
    end
    checks++;
    if (pop_cyc_q.size() != 8 || pop_cyc_q[7] - pop_cyc_q[0] != 7 ||
        re_cyc_q.size() == 0 || pop_cyc_q[0] - re_cyc_q[0] != 2) begin
      errors++; $display("FAIL stream_rsp_timing: got %0d responses, required 8 consecutive at +2",
                         pop_cyc_q.size());
    end
  endtask

  task automatic test_backpressure();
    bit to;
    clear_obs();
    rq_addr.push_back(16); rq_len.push_back(7);
    collect(2, 200, to);
    checks++;
    if (to || !data_matches()) begin
      errors++; $display("FAIL bp_data: got %0d words (timeout=%0d), required 8 in order",
                         got_q.size(), to);
    end
    checks++;
    if (stab_err != 0) begin
      errors++; $display("FAIL bp_hold: got %0d unstable stall cycles, required 0", stab_err);
    end
    checks++;
    if (credit_err != 0) begin
      errors++; $display("FAIL bp_credit: got %0d cycles over 2 outstanding, required 0", credit_err);
    end
    checks++;
    if (re_cyc_q.size() < 3 || re_cyc_q[2] - re_cyc_q[1] < 10) begin
      errors++; $display("FAIL bp_stall: got %0d issues / short stall, required stall after 2",
                         re_cyc_q.size());
    end
  endtask

  task automatic test_random_ready();
    bit to;
    clear_obs();
    rq_addr.push_back(16); rq_len.push_back(7);
    collect(1, 300, to);
    checks++;
    if (to || !data_matches() || stab_err != 0 || credit_err != 0) begin
      errors++;
      $display("FAIL rand_ready: got %0d words stab=%0d credit=%0d timeout=%0d, required 8/0/0/0",
               got_q.size(), stab_err, credit_err, to);
    end
  endtask

  task automatic test_wrap();
    bit to;
    clear_obs();
    rq_addr.push_back(1022); rq_len.push_back(3);
    collect(0, 100, to);
    checks++;
    if (to || !addr_matches()) begin
      errors++; $display("FAIL wrap_raddr: got %0d issues, required 1022,1023,0,1", raddr_q.size());
    end
    checks++;
    if (!data_matches()) begin
      errors++; $display("FAIL wrap_data: got %0d words, required 4 in wrapped order", got_q.size());
    end
  endtask

  task automatic test_max_b2b();
    bit to;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    clear_obs();
    rq_addr.push_back(0);   rq_len.push_back(255);
    rq_addr.push_back(512); rq_len.push_back(1);
    collect(0, 600, to);
    checks++;
    if (to || !data_matches() || !addr_matches()) begin
      errors++; $display("FAIL maxb2b_data: got %0d words (timeout=%0d), required 258 in order",
                         got_q.size(), to);
    end
    checks++;
    if (re_cyc_q.size() != 258 || re_cyc_q[255] - re_cyc_q[0] != 255) begin
      errors++; $display("FAIL maxb2b_stream: got %0d issues, required 256 consecutive then 2",
                         re_cyc_q.size());
    end
    checks++;
    if (re_cyc_q.size() < 257 || re_cyc_q[256] - re_cyc_q[255] != 2) begin
      errors++; $display("FAIL maxb2b_gap: got %0d issues / wrong gap, required one idle cycle",
                         re_cyc_q.size());
    end
  endtask

  task automatic test_random_bursts();
    bit to;
    clear_obs();
    for (int i = 0; i < 6; i++) begin
      rq_addr.push_back(int'($urandom_range(0, 1023)));
      rq_len.push_back(int'($urandom_range(0, 15)));
    end
    collect(1, 1000, to);
    checks++;
    if (to || !data_matches() || !addr_matches()) begin
      errors++; $display("FAIL rand_bursts_data: got %0d words (timeout=%0d), required %0d",
                         got_q.size(), to, exp_q.size());
    end
    checks++;
    if (stab_err != 0 || credit_err != 0) begin
      errors++; $display("FAIL rand_bursts_flow: got stab=%0d credit=%0d, required 0/0",
                         stab_err, credit_err);
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    int n_iss = 0;
    int n_pop = 0;
    bit rdy;
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = 10'd100;
    bus.req_len_i   = 8'd7;
    for (int i = 0; i < 30 && n_iss < 3; i++) begin
      @(negedge clk);
      bus.req_valid_i = 1'b0;
      rdy = bus.rsp_valid_o && n_iss == 2 && n_pop == 0;
      bus.rsp_ready_i = rdy;
      #1;
      if (bus.ram_re_o) n_iss++;
      if (bus.rsp_valid_o && rdy) n_pop++;
    end
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (n_iss != 3 || bus.rsp_valid_o !== 1'b1 || bus.ram_re_o !== 1'b0) begin
      errors++; $display("FAIL midrst_setup: got issues=%0d valid=%b re=%b, required 3/1/0",
                         n_iss, bus.rsp_valid_o, bus.ram_re_o);
    end
    #1;
    bus.rsp_ready_i = 1'b1;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.rsp_valid_o !== 1'b0 || bus.ram_re_o !== 1'b0 || bus.req_ready_o !== 1'b1) begin
      errors++; $display("FAIL midrst_async: got valid=%b re=%b req_ready=%b, required 0/0/1",
                         bus.rsp_valid_o, bus.ram_re_o, bus.req_ready_o);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_obs();
    rq_addr.push_back(40); rq_len.push_back(0);
    collect(0, 50, to);
    checks++;
    if (to || !data_matches()) begin
      errors++; $display("FAIL midrst_after: got %0d words (first %h), required only mem[40]=%h",
                         got_q.size(), (got_q.size() > 0) ? got_q[0] : 32'h0, mem[40]);
    end
  endtask

  initial begin
    bus.ram_dout_i = '0;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_random_ready();
    test_wrap();
    test_max_b2b();
    test_random_bursts();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
